// File: rtl/prefetch_fill_ctrl.sv
// Prefetch buffer write-port sequencer: tag sweep on reset/flush, line fill on read miss, snoop write-through.
// Buffer writes are registered (1 cycle after cause); fill beats cannot stall, so a colliding snoop sees SnpRdy=0 and holds.
module prefetch_fill_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int ENTRIES    = 128
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        RdReq,
    input  logic [25:0] RdA,
    input  logic        Match,
    input  logic        FlushReq,
    output logic        Busy,
    output logic        MemReq,
    output logic [25:0] MemA,
    input  logic        MemAck,
    input  logic        MemDV,
    input  logic [31:0] MemD,
    input  logic        SnpWR,
    input  logic [25:0] SnpA,
    input  logic [31:0] SnpD,
    input  logic [3:0]  SnpM,
    output logic        SnpRdy,
    output logic [25:0] WRA,
    output logic [31:0] WRD,
    output logic        WR,
    output logic [3:0]  WRM,
    output logic        CLR
);

    localparam int BW = $clog2(LINE_WORDS);
    localparam int IW = $clog2(ENTRIES);
    localparam logic [25:0] LINE_MASK = ~26'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_REQ,
        ST_FILL
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           clr_cnt_q, clr_cnt_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic [LINE_WORDS-1:0]   poison_q, poison_d;
    logic                    flush_pend_q, flush_pend_d;
    logic                    mem_req_q, mem_req_d;
    logic [25:0]             mem_a_q, mem_a_d;
    logic                    wr_q, wr_d;
    logic                    clr_q, clr_d;
    logic [3:0]              wrm_q, wrm_d;
    logic [25:0]             wra_q, wra_d;
    logic [31:0]             wrd_q, wrd_d;

    logic                    snp_rdy;
    logic                    snp_acc;
    logic                    snp_hits_line;
    logic [BW-1:0]           snp_off;

    assign snp_rdy       = ~((state_q == ST_FILL) & MemDV);
    assign snp_acc       = SnpWR & snp_rdy;
    assign snp_hits_line = (SnpA & LINE_MASK) == mem_a_q;
    assign snp_off       = SnpA[BW-1:0];

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        beat_d       = beat_q;
        poison_d     = poison_q;
        flush_pend_d = flush_pend_q;
        mem_req_d    = mem_req_q;
        mem_a_d      = mem_a_q;
        wr_d         = 1'b0;
        clr_d        = 1'b0;
        wrm_d        = wrm_q;
        wra_d        = wra_q;
        wrd_d        = wrd_q;

        // Snoops during the sweep are dropped: every tag ends up invalid anyway.
        if (state_q != ST_CLEAR && snp_acc) begin
            wr_d  = 1'b1;
            clr_d = 1'b0;
            wra_d = SnpA;
            wrd_d = SnpD;
            wrm_d = SnpM;
            if ((state_q == ST_REQ || state_q == ST_FILL) && snp_hits_line)
                poison_d[snp_off] = 1'b1;
        end

        case (state_q)
            ST_CLEAR: begin
                wr_d      = 1'b1;
                clr_d     = 1'b1;
                wrm_d     = 4'hF;
                wra_d     = 26'(clr_cnt_q);
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (FlushReq)
                    flush_pend_d = 1'b1;
                if (clr_cnt_q == IW'(ENTRIES - 1)) begin
                    clr_cnt_d = '0;
                    state_d   = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (FlushReq || flush_pend_q) begin
                    flush_pend_d = 1'b0;
                    clr_cnt_d    = '0;
                    state_d      = ST_CLEAR;
                end else if (RdReq && !Match) begin
                    mem_a_d   = RdA & LINE_MASK;
                    mem_req_d = 1'b1;
                    state_d   = ST_REQ;
                end
            end

            ST_REQ: begin
                if (FlushReq)
                    flush_pend_d = 1'b1;
                if (MemAck) begin
                    mem_req_d = 1'b0;
                    beat_d    = '0;
                    state_d   = ST_FILL;
                end
            end

            ST_FILL: begin
                if (FlushReq)
                    flush_pend_d = 1'b1;
                if (MemDV) begin
                    wr_d   = 1'b1;
                    clr_d  = poison_q[beat_q];
                    wrm_d  = 4'hF;
                    wra_d  = mem_a_q | 26'(beat_q);
                    wrd_d  = MemD;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == BW'(LINE_WORDS - 1)) begin
                        beat_d   = '0;
                        poison_d = '0;
                        state_d  = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q      <= ST_CLEAR;
            clr_cnt_q    <= '0;
            beat_q       <= '0;
            poison_q     <= '0;
            flush_pend_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_a_q      <= '0;
            wr_q         <= 1'b0;
            clr_q        <= 1'b0;
            wrm_q        <= '0;
            wra_q        <= '0;
            wrd_q        <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            beat_q       <= beat_d;
            poison_q     <= poison_d;
            flush_pend_q <= flush_pend_d;
            mem_req_q    <= mem_req_d;
            mem_a_q      <= mem_a_d;
            wr_q         <= wr_d;
            clr_q        <= clr_d;
            wrm_q        <= wrm_d;
            wra_q        <= wra_d;
            wrd_q        <= wrd_d;
        end
    end

    assign Busy   = (state_q != ST_IDLE);
    assign SnpRdy = snp_rdy;
    assign MemReq = mem_req_q;
    assign MemA   = mem_a_q;
    assign WR     = wr_q;
    assign CLR    = clr_q;
    assign WRM    = wrm_q;
    assign WRA    = wra_q;
    assign WRD    = wrd_q;

endmodule

// File: tb/tb_prefetch_fill_ctrl.sv
// Directed bench for prefetch_fill_ctrl: sweep, fill, snoop poison/collision, flush and reset scenarios.
module tb_prefetch_fill_ctrl;

    logic        CLK = 1'b0;
    logic        nRESET;
    logic        RdReq;
    logic [25:0] RdA;
    logic        Match;
    logic        FlushReq;
    logic        Busy;
    logic        MemReq;
    logic [25:0] MemA;
    logic        MemAck;
    logic        MemDV;
    logic [31:0] MemD;
    logic        SnpWR;
    logic [25:0] SnpA;
    logic [31:0] SnpD;
    logic [3:0]  SnpM;
    logic        SnpRdy;
    logic [25:0] WRA;
    logic [31:0] WRD;
    logic        WR;
    logic [3:0]  WRM;
    logic        CLR;

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] wport;
    assign wport = {WR, CLR, WRM, WRA, WRD};

    prefetch_fill_ctrl #(.LINE_WORDS(4), .ENTRIES(128)) dut (
        .CLK      (CLK),
        .nRESET   (nRESET),
        .RdReq    (RdReq),
        .RdA      (RdA),
        .Match    (Match),
        .FlushReq (FlushReq),
        .Busy     (Busy),
        .MemReq   (MemReq),
        .MemA     (MemA),
        .MemAck   (MemAck),
        .MemDV    (MemDV),
        .MemD     (MemD),
        .SnpWR    (SnpWR),
        .SnpA     (SnpA),
        .SnpD     (SnpD),
        .SnpM     (SnpM),
        .SnpRdy   (SnpRdy),
        .WRA      (WRA),
        .WRD      (WRD),
        .WR       (WR),
        .WRM      (WRM),
        .CLR      (CLR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Miss on addr, acknowledge the burst request; leaves the DUT in FILL.
    task automatic start_fill(input logic [25:0] addr);
        RdReq = 1'b1; RdA = addr; Match = 1'b0;
        tick;
        RdReq = 1'b0;
        MemAck = 1'b1;
        tick;
        MemAck = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d);
        MemDV = 1'b1; MemD = d;
        tick;
        MemDV = 1'b0;
    endtask

    task automatic test_reset;
        nRESET = 1'b0; RdReq = 0; RdA = '0; Match = 0; FlushReq = 0;
        MemAck = 0; MemDV = 0; MemD = '0; SnpWR = 0; SnpA = '0; SnpD = '0; SnpM = '0;
        #3;
        n_chk++;
        if ({WR, CLR, WRM, MemReq, Busy, SnpRdy} !== 9'b0_0_0000_0_1_1) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected %b", {WR, CLR, WRM, MemReq, Busy, SnpRdy}, 9'b000000011);
        end
        n_chk++;
        if ({WRA, WRD, MemA} !== 84'd0) begin
            n_fail++;
            $display("FAIL reset_data: got WRA=%h WRD=%h MemA=%h expected all 0", WRA, WRD, MemA);
        end
        tick; tick;
        n_chk++;
        if ({WR, Busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_hold: got WR,Busy=%b expected 01", {WR, Busy});
        end
    endtask

    task automatic check_sweep(input string name);
        int errs = 0;
        for (int i = 0; i < 128; i++) begin
            tick;
            n_chk++;
            if (wport[63:32] !== {1'b1, 1'b1, 4'hF, 26'(i)}) begin
                n_fail++;
                errs++;
                if (errs < 5)
                    $display("FAIL %s idx %0d: got WR,CLR,WRM,WRA=%h expected %h", name, i,
                             wport[63:32], {1'b1, 1'b1, 4'hF, 26'(i)});
            end
        end
        n_chk++;
        if (Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_end_busy: got %b expected 0", name, Busy);
        end
    endtask

    task automatic test_clear_sweep;
        int errs = 0;
        nRESET = 1'b1;
        n_chk++;
        if ({Busy, WR} !== 2'b10) begin
            n_fail++;
            $display("FAIL sweep_start: got Busy,WR=%b expected 10", {Busy, WR});
        end
        for (int i = 0; i < 128; i++) begin
            if (i == 40) begin
                SnpWR = 1; SnpA = 26'h5; SnpD = 32'h12345678; SnpM = 4'h3;
                RdReq = 1; RdA = 26'h999; Match = 0;
                #1;
                n_chk++;
                if (SnpRdy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sweep_snprdy: got %b expected 1", SnpRdy);
                end
            end
            tick;
            SnpWR = 0; RdReq = 0;
            n_chk++;
            if (wport[63:32] !== {1'b1, 1'b1, 4'hF, 26'(i)}) begin
                n_fail++;
                errs++;
                if (errs < 5)
                    $display("FAIL sweep idx %0d: got %h expected %h", i, wport[63:32], {1'b1, 1'b1, 4'hF, 26'(i)});
            end
        end
        n_chk++;
        if (Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_busy_fall: got %b expected 0", Busy);
        end
        tick;
        n_chk++;
        if ({WR, MemReq, Busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL sweep_after: got WR,MemReq,Busy=%b expected 000", {WR, MemReq, Busy});
        end
    endtask

    task automatic test_fill_basic;
        logic [31:0] d;
        RdReq = 1; RdA = 26'h50; Match = 1;
        tick;
        RdReq = 0; Match = 0;
        n_chk++;
        if ({MemReq, Busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL hit_no_action: got MemReq,Busy=%b expected 00", {MemReq, Busy});
        end
        RdReq = 1; RdA = 26'h123;
        tick;
        RdReq = 0;
        n_chk++;
        if ({MemReq, Busy, MemA} !== {2'b11, 26'h120}) begin
            n_fail++;
            $display("FAIL miss_req: got MemReq,Busy=%b MemA=%h expected 11 120", {MemReq, Busy}, MemA);
        end
        tick; tick;
        n_chk++;
        if ({MemReq, MemA} !== {1'b1, 26'h120}) begin
            n_fail++;
            $display("FAIL req_hold: got MemReq=%b MemA=%h expected 1 120", MemReq, MemA);
        end
        MemAck = 1;
        tick;
        MemAck = 0;
        n_chk++;
        if ({MemReq, Busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL ack_drop: got MemReq,Busy=%b expected 01", {MemReq, Busy});
        end
        for (int b = 0; b < 4; b++) begin
            if (b == 2) begin
                tick;
                n_chk++;
                if (WR !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fill_gap: got WR=%b expected 0", WR);
                end
            end
            if (b == 1) begin
                RdReq = 1; RdA = 26'h888; Match = 0;
            end
            d = 32'hDA7A0000 + 32'(b);
            send_beat(d);
            RdReq = 0;
            n_chk++;
            if (wport !== {1'b1, 1'b0, 4'hF, 26'h120 + 26'(b), d}) begin
                n_fail++;
                $display("FAIL fill_beat%0d: got %h expected %h", b, wport, {1'b1, 1'b0, 4'hF, 26'h120 + 26'(b), d});
            end
        end
        n_chk++;
        if ({Busy, MemReq} !== 2'b00) begin
            n_fail++;
            $display("FAIL fill_done: got Busy,MemReq=%b expected 00", {Busy, MemReq});
        end
        tick;
        n_chk++;
        if ({WR, MemReq, Busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL busy_rdreq_ignored: got WR,MemReq,Busy=%b expected 000", {WR, MemReq, Busy});
        end
    endtask

    task automatic test_snoop_poison;
        start_fill(26'h122);
        send_beat(32'hB0);
        n_chk++;
        if (wport !== {1'b1, 1'b0, 4'hF, 26'h120, 32'hB0}) begin
            n_fail++;
            $display("FAIL poison_beat0: got %h expected %h", wport, {1'b1, 1'b0, 4'hF, 26'h120, 32'hB0});
        end
        send_beat(32'hB1);
        n_chk++;
        if (wport !== {1'b1, 1'b0, 4'hF, 26'h121, 32'hB1}) begin
            n_fail++;
            $display("FAIL poison_beat1: got %h expected %h", wport, {1'b1, 1'b0, 4'hF, 26'h121, 32'hB1});
        end
        SnpWR = 1; SnpA = 26'h122; SnpD = 32'hC0FFEE00; SnpM = 4'b0011;
        #1;
        n_chk++;
        if (SnpRdy !== 1'b1) begin
            n_fail++;
            $display("FAIL poison_snprdy: got %b expected 1", SnpRdy);
        end
        tick;
        n_chk++;
        if (wport !== {1'b1, 1'b0, 4'b0011, 26'h122, 32'hC0FFEE00}) begin
            n_fail++;
            $display("FAIL snoop_write: got %h expected %h", wport, {1'b1, 1'b0, 4'b0011, 26'h122, 32'hC0FFEE00});
        end
        SnpA = 26'h203; SnpD = 32'h11112222; SnpM = 4'b1100;
        tick;
        SnpWR = 0;
        n_chk++;
        if (wport !== {1'b1, 1'b0, 4'b1100, 26'h203, 32'h11112222}) begin
            n_fail++;
            $display("FAIL snoop_other_line: got %h expected %h", wport, {1'b1, 1'b0, 4'b1100, 26'h203, 32'h11112222});
        end
        send_beat(32'hB2);
        n_chk++;
        if (wport !== {1'b1, 1'b1, 4'hF, 26'h122, 32'hB2}) begin
            n_fail++;
            $display("FAIL poison_beat2: got %h expected %h", wport, {1'b1, 1'b1, 4'hF, 26'h122, 32'hB2});
        end
        send_beat(32'hB3);
        n_chk++;
        if (wport !== {1'b1, 1'b0, 4'hF, 26'h123, 32'hB3}) begin
            n_fail++;
            $display("FAIL poison_beat3: got %h expected %h", wport, {1'b1, 1'b0, 4'hF, 26'h123, 32'hB3});
        end
    endtask

    task automatic test_snoop_collision;
        logic [31:0] d;
        start_fill(26'h341);
        MemDV = 1; MemD = 32'hE0;
        SnpWR = 1; SnpA = 26'h555; SnpD = 32'h55550000; SnpM = 4'b1010;
        #1;
        n_chk++;
        if (SnpRdy !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_snprdy: got %b expected 0", SnpRdy);
        end
        tick;
        MemDV = 0;
        n_chk++;
        if (wport !== {1'b1, 1'b0, 4'hF, 26'h340, 32'hE0}) begin
            n_fail++;
            $display("FAIL collide_beat: got %h expected %h", wport, {1'b1, 1'b0, 4'hF, 26'h340, 32'hE0});
        end
        #1;
        n_chk++;
        if (SnpRdy !== 1'b1) begin
            n_fail++;
            $display("FAIL collide_snprdy_after: got %b expected 1", SnpRdy);
        end
        tick;
        SnpWR = 0;
        n_chk++;
        if (wport !== {1'b1, 1'b0, 4'b1010, 26'h555, 32'h55550000}) begin
            n_fail++;
            $display("FAIL collide_snoop: got %h expected %h", wport, {1'b1, 1'b0, 4'b1010, 26'h555, 32'h55550000});
        end
        MemDV = 1;
        for (int b = 1; b < 4; b++) begin
            d = 32'hE0 + 32'(b);
            MemD = d;
            tick;
            n_chk++;
            if (wport !== {1'b1, 1'b0, 4'hF, 26'h340 + 26'(b), d}) begin
                n_fail++;
                $display("FAIL b2b_beat%0d: got %h expected %h", b, wport, {1'b1, 1'b0, 4'hF, 26'h340 + 26'(b), d});
            end
        end
        MemDV = 0;
        n_chk++;
        if (Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done: got Busy=%b expected 0", Busy);
        end
        SnpWR = 1; SnpA = 26'h341; SnpD = 32'h0BADF00D; SnpM = 4'b0110;
        tick;
        SnpWR = 0;
        n_chk++;
        if (wport !== {1'b1, 1'b0, 4'b0110, 26'h341, 32'h0BADF00D}) begin
            n_fail++;
            $display("FAIL idle_snoop: got %h expected %h", wport, {1'b1, 1'b0, 4'b0110, 26'h341, 32'h0BADF00D});
        end
    endtask

    task automatic test_flush_during_fill;
        logic [31:0] d;
        start_fill(26'h402);
        send_beat(32'hF0);
        FlushReq = 1;
        tick;
        FlushReq = 0;
        n_chk++;
        if ({WR, Busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL flush_fill_cont: got WR,Busy=%b expected 01", {WR, Busy});
        end
        for (int b = 1; b < 4; b++) begin
            d = 32'hF0 + 32'(b);
            send_beat(d);
            n_chk++;
            if (wport !== {1'b1, 1'b0, 4'hF, 26'h400 + 26'(b), d}) begin
                n_fail++;
                $display("FAIL flush_beat%0d: got %h expected %h", b, wport, {1'b1, 1'b0, 4'hF, 26'h400 + 26'(b), d});
            end
        end
        n_chk++;
        if (Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_fill_done: got Busy=%b expected 0", Busy);
        end
        RdReq = 1; RdA = 26'h777; Match = 0;
        tick;
        RdReq = 0;
        n_chk++;
        if ({MemReq, Busy, WR} !== 3'b010) begin
            n_fail++;
            $display("FAIL flush_priority: got MemReq,Busy,WR=%b expected 010", {MemReq, Busy, WR});
        end
        check_sweep("flush_sweep");
    endtask

    task automatic test_reset_mid_fill;
        start_fill(26'h600);
        send_beat(32'h60);
        send_beat(32'h61);
        MemDV = 1; MemD = 32'h62;
        nRESET = 0;
        #1;
        n_chk++;
        if ({MemReq, WR, Busy} !== 3'b001 || wport !== 64'd0 || MemA !== 26'd0) begin
            n_fail++;
            $display("FAIL mid_fill_reset: got MemReq,WR,Busy=%b wport=%h MemA=%h expected 001 0 0",
                     {MemReq, WR, Busy}, wport, MemA);
        end
        tick; tick;
        MemDV = 0;
        nRESET = 1;
        check_sweep("reset_sweep");
    endtask

    initial begin
        test_reset;
        test_clear_sweep;
        test_fill_basic;
        test_snoop_poison;
        test_snoop_collision;
        test_flush_during_fill;
        test_reset_mid_fill;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
